hero_write_packer: RTL and testbench

HERO_WRITE_PACKER -- requirements
Module: hero_write_packer

---
 rtl/hero_write_packer.sv | 160 ++++++++++++++++
 tb/tb_hero_write_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hero_write_packer.sv
// Packs qualified hero write bus cycles into framed beats (sop/eop/idx) and buffers them
// in a small output FIFO with a valid/ready consumer interface and sticky error flags.

package hero_write_pkg;

    typedef logic [6:0] sub_def_t;

    localparam logic [1:0] CYC_IDLE    = 2'd0;
    localparam logic [1:0] CYC_VALID   = 2'd1;
    localparam logic [1:0] CYC_DONE    = 2'd2;
    localparam logic [1:0] CYC_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [1:0]  cycle_type;
        logic [35:0] wdat;
        sub_def_t    another_type_reference;
        logic        clk_en;
    } hero_write_t;

endpackage

module hero_write_packer
    import hero_write_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  hero_write_t                  in_hero,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [35:0]                  out_wdat,
    output sub_def_t                     out_sub,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [$clog2(MAX_BEATS)-1:0] out_idx,
    output logic [2:0]                   err_sticky,
    input  logic                         err_clr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned IDX_W = $clog2(MAX_BEATS);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [35:0]      wdat;
        sub_def_t         sub;
        logic             sop;
        logic             eop;
        logic [IDX_W-1:0] idx;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StBusy, StDrop} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, next_idx;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       err_q, err_d, err_set;
    entry_t           mem [DEPTH];
    entry_t           push_entry, head;
    logic             beat_vld, is_done, pop, push, push_ok;

    assign beat_vld = in_hero.clk_en &&
                      (in_hero.cycle_type == CYC_VALID || in_hero.cycle_type == CYC_DONE);
    assign is_done  = (in_hero.cycle_type == CYC_DONE);
    assign pop      = (count_q != '0) && out_rdy;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign push_ok  = (count_q < CNT_W'(DEPTH)) || pop;
    assign next_idx = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        push       = 1'b0;
        err_set    = '0;
        push_entry = '{wdat: in_hero.wdat, sub: in_hero.another_type_reference,
                       sop: 1'b0, eop: 1'b0, idx: '0};

        if (in_hero.clk_en && in_hero.cycle_type == CYC_ILLEGAL) begin
            err_set[2] = 1'b1;
        end else if (beat_vld) begin
            unique case (state_q)
                StIdle: begin
                    if (push_ok) begin
                        push           = 1'b1;
                        push_entry.sop = 1'b1;
                        push_entry.eop = is_done;
                        idx_d          = '0;
                        state_d        = is_done ? StIdle : StBusy;
                    end else begin
                        err_set[0] = 1'b1;
                        state_d    = is_done ? StIdle : StDrop;
                    end
                end
                StBusy: begin
                    if (push_ok) begin
                        push           = 1'b1;
                        push_entry.idx = next_idx;
                        idx_d          = next_idx;
                        if (is_done) begin
                            push_entry.eop = 1'b1;
                            state_d        = StIdle;
                        end else if (next_idx == IDX_W'(MAX_BEATS - 1)) begin
                            // Index space exhausted: close the frame and discard the rest.
                            push_entry.eop = 1'b1;
                            err_set[1]     = 1'b1;
                            state_d        = StDrop;
                        end
                    end else begin
                        err_set[0] = 1'b1;
                        state_d    = is_done ? StIdle : StDrop;
                    end
                end
                StDrop: begin
                    if (is_done) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        err_d   = (err_clr ? 3'b000 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            err_q    <= err_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_entry;
    end

    assign head       = mem[rd_ptr_q];
    assign out_vld    = (count_q != '0);
    assign out_wdat   = head.wdat;
    assign out_sub    = head.sub;
    assign out_sop    = out_vld && head.sop;
    assign out_eop    = out_vld && head.eop;
    assign out_idx    = out_vld ? head.idx : '0;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_hero_write_packer.sv
// Directed bench for hero_write_packer: inputs driven and outputs checked on the falling edge.

module tb_hero_write_packer;
    import hero_write_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    hero_write_t in_hero;
    logic        out_vld;
    logic        out_rdy;
    logic [35:0] out_wdat;
    sub_def_t    out_sub;
    logic        out_sop;
    logic        out_eop;
    logic [3:0]  out_idx;
    logic [2:0]  err_sticky;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;

    hero_write_packer #(.DEPTH(8), .MAX_BEATS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_hero    (in_hero),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_wdat   (out_wdat),
        .out_sub    (out_sub),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_idx    (out_idx),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ct, input logic [35:0] w, input logic en);
        in_hero = {ct, w, w[6:0] ^ 7'h2a, en};
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input logic [35:0] w, input logic sop,
                        input logic eop, input logic [3:0] idx);
        check({tag, ".vld"}, 64'(out_vld), 64'(1'b1));
        check({tag, ".wdat"}, 64'(out_wdat), 64'(w));
        check({tag, ".sop"}, 64'(out_sop), 64'(sop));
        check({tag, ".eop"}, 64'(out_eop), 64'(eop));
        check({tag, ".idx"}, 64'(out_idx), 64'(idx));
    endtask

    initial begin
        rst_n   = 1'b0;
        out_rdy = 1'b0;
        err_clr = 1'b0;
        drive(CYC_VALID, 36'h123, 1'b1);
        tick();
        tick();
        check("rst.vld", 64'(out_vld), 64'(1'b0));
        check("rst.sop", 64'(out_sop), 64'(1'b0));
        check("rst.eop", 64'(out_eop), 64'(1'b0));
        check("rst.idx", 64'(out_idx), 64'(4'd0));
        check("rst.err", 64'(err_sticky), 64'(3'b000));
        drive(CYC_IDLE, 36'h0, 1'b1);
        rst_n = 1'b1;
        tick();

        // Three-beat frame with the consumer always ready.
        out_rdy = 1'b1;
        drive(CYC_VALID, 36'hA, 1'b1);
        tick();
        beat("abc.a", 36'hA, 1'b1, 1'b0, 4'd0);
        drive(CYC_VALID, 36'hB, 1'b1);
        tick();
        beat("abc.b", 36'hB, 1'b0, 1'b0, 4'd1);
        drive(CYC_DONE, 36'hC, 1'b1);
        tick();
        beat("abc.c", 36'hC, 1'b0, 1'b1, 4'd2);
        check("abc.sub", 64'(out_sub), 64'(7'h0c ^ 7'h2a));
        drive(CYC_IDLE, 36'h0, 1'b1);
        tick();
        check("abc.empty", 64'(out_vld), 64'(1'b0));
        check("abc.err", 64'(err_sticky), 64'(3'b000));

        // Single DONE from idle.
        drive(CYC_DONE, 36'hD, 1'b1);
        tick();
        beat("single", 36'hD, 1'b1, 1'b1, 4'd0);
        drive(CYC_IDLE, 36'h0, 1'b1);
        tick();

        // Overflow: nine VALID beats into an eight-deep FIFO, then DONE.
        out_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(CYC_VALID, 36'h100 + 36'(i), 1'b1);
            tick();
        end
        drive(CYC_DONE, 36'h1ff, 1'b1);
        tick();
        drive(CYC_IDLE, 36'h0, 1'b1);
        check("ovf.err", 64'(err_sticky), 64'(3'b001));
        beat("ovf.head", 36'h100, 1'b1, 1'b0, 4'd0);
        tick();
        tick();
        check("ovf.stable", 64'(out_wdat), 64'(36'h100));
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat("ovf.drain", 36'h100 + 36'(i), (i == 0), 1'b0, 4'(i));
            tick();
        end
        check("ovf.empty", 64'(out_vld), 64'(1'b0));
        drive(CYC_DONE, 36'h200, 1'b1);
        tick();
        drive(CYC_IDLE, 36'h0, 1'b1);
        beat("ovf.idle", 36'h200, 1'b1, 1'b1, 4'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf.clr", 64'(err_sticky), 64'(3'b000));

        // Too long: 17 VALID beats then DONE.
        for (int k = 0; k < 19; k++) begin
            if (k >= 1 && k <= 16) begin
                beat("long", 36'h300 + 36'(k - 1), (k == 1), (k == 16), 4'(k - 1));
            end else if (k >= 17) begin
                check("long.drop", 64'(out_vld), 64'(1'b0));
            end
            if (k < 17)       drive(CYC_VALID, 36'h300 + 36'(k), 1'b1);
            else if (k == 17) drive(CYC_DONE, 36'h3ff, 1'b1);
            else              drive(CYC_IDLE, 36'h0, 1'b1);
            tick();
        end
        check("long.err", 64'(err_sticky), 64'(3'b010));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Illegal cycle type and gated beats in the middle of a frame.
        drive(CYC_VALID, 36'h500, 1'b1);
        tick();
        beat("ill.first", 36'h500, 1'b1, 1'b0, 4'd0);
        drive(CYC_ILLEGAL, 36'h501, 1'b1);
        tick();
        check("ill.nopush", 64'(out_vld), 64'(1'b0));
        check("ill.err", 64'(err_sticky), 64'(3'b100));
        drive(CYC_VALID, 36'h502, 1'b0);
        tick();
        check("ill.gated", 64'(out_vld), 64'(1'b0));
        drive(CYC_VALID, 36'h503, 1'b0);
        tick();
        drive(CYC_DONE, 36'h504, 1'b1);
        tick();
        beat("ill.done", 36'h504, 1'b0, 1'b1, 4'd1);
        drive(CYC_ILLEGAL, 36'h0, 1'b1);
        err_clr = 1'b1;
        tick();
        check("ill.setwins", 64'(err_sticky), 64'(3'b100));
        drive(CYC_IDLE, 36'h0, 1'b1);
        tick();
        err_clr = 1'b0;
        check("ill.clr", 64'(err_sticky), 64'(3'b000));

        // Reset in the middle of a buffered frame.
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(CYC_VALID, 36'h600 + 36'(i), 1'b1);
            tick();
        end
        drive(CYC_IDLE, 36'h0, 1'b1);
        check("mrst.pre", 64'(out_vld), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        drive(CYC_DONE, 36'h6ff, 1'b1);
        #1;
        check("mrst.vld", 64'(out_vld), 64'(1'b0));
        check("mrst.sop", 64'(out_sop), 64'(1'b0));
        check("mrst.idx", 64'(out_idx), 64'(4'd0));
        tick();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        drive(CYC_DONE, 36'hE, 1'b1);
        tick();
        drive(CYC_IDLE, 36'h0, 1'b1);
        beat("mrst.e", 36'hE, 1'b1, 1'b1, 4'd0);
        tick();
        check("mrst.flushed", 64'(out_vld), 64'(1'b0));

        // Full FIFO accepts a beat when a pop happens in the same cycle.
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(CYC_VALID, 36'h700 + 36'(i), 1'b1);
            tick();
        end
        out_rdy = 1'b1;
        drive(CYC_DONE, 36'h7ff, 1'b1);
        tick();
        drive(CYC_IDLE, 36'h0, 1'b1);
        check("full.err", 64'(err_sticky), 64'(3'b000));
        for (int i = 1; i < 9; i++) begin
            beat("full.drain", (i < 8) ? 36'h700 + 36'(i) : 36'h7ff, 1'b0, (i == 8), 4'(i));
            tick();
        end
        check("full.empty", 64'(out_vld), 64'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
